// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the flop-based FIFO with thresholds.
package fifo_pkg;
  localparam int DEF_BITS   = 32;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_AF_LVL = DEF_DEPTH - 2;
  localparam int DEF_AE_LVL = 2;

  // Count must hold 0..DEPTH inclusive, hence one bit more than the pointers.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer register; relies on power-of-two depth for natural wrap.
module fifo_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/fifo_flops_thr.sv
// First-word-fall-through FIFO in flops with almost-full/empty thresholds
// and sticky overflow/underflow flags.
module fifo_flops_thr
  import fifo_pkg::*;
#(
  parameter int BITS   = DEF_BITS,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = DEF_AE_LVL
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BITS-1:0]         Din,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clr_err,
  output logic [BITS-1:0]         Dout,
  output logic                    full,
  output logic                    pndng,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (BITS < 1) begin : g_bad_bits
    $error("fifo_flops_thr: BITS must be >= 1");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_flops_thr: DEPTH must be a power of two >= 4");
  end
  if (AF_LVL < 1 || AF_LVL > DEPTH - 1) begin : g_bad_af
    $error("fifo_flops_thr: AF_LVL out of range 1..DEPTH-1");
  end
  if (AE_LVL < 1 || AE_LVL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_flops_thr: AE_LVL out of range 1..DEPTH-1");
  end

  logic [BITS-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  // Handshake: pop is accepted only while an entry is pending (pndng acts as
  // valid); push is accepted when not full, or when full and a pop is accepted
  // in the same cycle. Unaccepted requests change nothing but raise a sticky flag.
  assign pop_ok  = pop & pndng;
  assign push_ok = push & (~full | pop_ok);

  fifo_ptr #(.W(AW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push_ok),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.W(AW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop_ok),
    .ptr (rd_ptr)
  );

  // Storage is intentionally not reset; the count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= Din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (push_ok && !pop_ok) begin
      count <= count + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count <= count - 1'b1;
    end
  end

  // A rejection in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && !push_ok) overflow <= 1'b1;
      else if (clr_err)     overflow <= 1'b0;
      if (pop && !pop_ok)   underflow <= 1'b1;
      else if (clr_err)     underflow <= 1'b0;
    end
  end

  assign full         = (count == CW'(DEPTH));
  assign pndng        = (count != '0);
  assign almost_full  = (count >= CW'(AF_LVL));
  assign almost_empty = (count <= CW'(AE_LVL));
  assign Dout         = pndng ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fifo_flops_thr.sv
// Directed and random stimulus for fifo_flops_thr checked against a queue model.
module tb_fifo_flops_thr;

  localparam int BITS  = 32;
  localparam int DEPTH = 16;
  localparam int AFL   = 14;
  localparam int AEL   = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [BITS-1:0] Din = '0;
  logic            push = 1'b0;
  logic            pop = 1'b0;
  logic            clr_err = 1'b0;
  logic [BITS-1:0] Dout;
  logic            full;
  logic            pndng;
  logic [4:0]      count;
  logic            almost_full;
  logic            almost_empty;
  logic            overflow;
  logic            underflow;

  logic [BITS-1:0] exp_q[$];
  logic            ovf_m = 1'b0;
  logic            udf_m = 1'b0;
  int              n_cmp = 0;
  int              n_err = 0;

  fifo_flops_thr #(.BITS(BITS), .DEPTH(DEPTH), .AF_LVL(AFL), .AE_LVL(AEL)) dut (
    .clk          (clk),
    .rst          (rst),
    .Din          (Din),
    .push         (push),
    .pop          (pop),
    .clr_err      (clr_err),
    .Dout         (Dout),
    .full         (full),
    .pndng        (pndng),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int sz;
    sz = exp_q.size();
    chk({tag, ".count"}, 32'(count), 32'(sz));
    chk({tag, ".full"}, 32'(full), 32'(sz == DEPTH));
    chk({tag, ".pndng"}, 32'(pndng), 32'(sz != 0));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(sz >= AFL));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AEL));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ovf_m));
    chk({tag, ".underflow"}, 32'(underflow), 32'(udf_m));
    chk({tag, ".dout"}, Dout, (sz != 0) ? exp_q[0] : 32'd0);
  endtask

  // Called just after a falling edge: drive, model, clock, then check.
  task automatic step(input string tag, input logic p, input logic q,
                      input logic [BITS-1:0] d, input logic ce);
    logic pop_acc;
    logic push_acc;
    push = p; pop = q; Din = d; clr_err = ce;
    pop_acc  = q && (exp_q.size() != 0);
    push_acc = p && ((exp_q.size() < DEPTH) || pop_acc);
    #1;
    if (pop_acc) chk({tag, ".head"}, Dout, exp_q[0]);
    @(posedge clk);
    if (pop_acc)  void'(exp_q.pop_front());
    if (push_acc) exp_q.push_back(d);
    if (p && !push_acc) ovf_m = 1'b1;
    else if (ce)        ovf_m = 1'b0;
    if (q && !pop_acc)  udf_m = 1'b1;
    else if (ce)        udf_m = 1'b0;
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clr_err = 1'b0; Din = '0;
    check_state(tag);
  endtask

  initial begin
    // Reset held from time zero.
    repeat (2) @(negedge clk);
    check_state("in_reset");
    rst = 1'b1;
    #1 check_state("after_reset");

    for (int i = 0; i < 16; i++) step("fill", 1'b1, 1'b0, 32'(i), 1'b0);
    step("overflow_push", 1'b1, 1'b0, 32'd99, 1'b0);
    step("clr_ovf", 1'b0, 1'b0, '0, 1'b1);

    for (int i = 0; i < 16; i++) step("drain", 1'b0, 1'b1, '0, 1'b0);
    step("underflow_pop", 1'b0, 1'b1, '0, 1'b0);
    step("clr_udf", 1'b0, 1'b0, '0, 1'b1);

    step("empty_push_pop", 1'b1, 1'b1, 32'd7, 1'b0);
    chk("empty_push_pop.dout7", Dout, 32'd7);
    step("clr_after_empty", 1'b0, 1'b0, '0, 1'b1);

    for (int i = 0; i < 15; i++) step("refill", 1'b1, 1'b0, 32'(200 + i), 1'b0);
    step("full_push_pop", 1'b1, 1'b1, 32'd100, 1'b0);
    chk("full_push_pop.ovf0", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) step("drain2", 1'b0, 1'b1, '0, 1'b0);

    for (int i = 0; i < 40; i++)
      step("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom(), 1'b0);

    while (exp_q.size() < 5) step("pre_rst_push", 1'b1, 1'b0, $urandom(), 1'b0);
    while (exp_q.size() > 5) step("pre_rst_pop", 1'b0, 1'b1, '0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    ovf_m = 1'b0;
    udf_m = 1'b0;
    #1 check_state("mid_reset");
    #1 rst = 1'b1;
    @(negedge clk);
    step("post_rst_push", 1'b1, 1'b0, 32'd42, 1'b0);
    chk("post_rst.dout42", Dout, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
